// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: register enables, bubble selects,
// data-memory req/ack sequencing with timeout, stall performance counter.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  mem_access,
  input  logic                  mem_branch_taken,
  input  logic                  dmem_ack,
  input  logic                  stall_cnt_clr,
  output logic                  dmem_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hazard_chk;
  logic timeout;
  logic load_use;

  assign timeout  = (wait_cnt_q == WAIT_LAST);
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    hazard_chk = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_access) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          hazard_chk = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || timeout) begin
          state_d    = RUN;
          hazard_chk = 1'b1;
          if (!dmem_ack) mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Memory stall outranks everything; hazards only resolve when it is clear.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (hazard_chk) begin
      if (mem_branch_taken) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_req  = (state_q == MEM_WAIT);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
